// File: rtl/ide_cycle_ctrl.sv
// ATA PIO cycle engine for 68030 accesses to the IDE window $DA0000-$DA3FFF.
// Generates chip selects, register address, IOR/IOW, buffer control and 16-bit DSACK.
module ide_cycle_ctrl #(
    parameter int SETUP_CYC     = 2,
    parameter int STROBE_CYC    = 6,
    parameter int HOLD_CYC      = 1,
    parameter int IORDY_TIMEOUT = 255
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW,
    input  logic [31:0] A,
    input  logic        IORDY,
    output logic        ACCESS,
    output logic        IDE_CS0,
    output logic        IDE_CS1,
    output logic [2:0]  IDE_A,
    output logic        IDE_IOR,
    output logic        IDE_IOW,
    output logic        IDE_DBEN,
    output logic        IDE_DIR,
    output logic        RD_LATCH,
    output logic [1:0]  DSACK,
    output logic        TIMEOUT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] IORDY_LAST  = 8'(IORDY_TIMEOUT);

    logic [2:0] state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] iordy_q, iordy_d;
    logic       rw_q, rw_d, sel_q, sel_d, dummy_q, dummy_d;
    logic       abort_q, abort_d, armed_q, armed_d, timeout_q, timeout_d;
    logic [2:0] addr_q, addr_d;

    logic       cs0_q, cs0_d, cs1_q, cs1_d, ior_q, ior_d, iow_q, iow_d;
    logic       dben_q, dben_d, dir_q, dir_d, rd_latch_q, rd_latch_d;
    logic [2:0] ide_a_q, ide_a_d;
    logic [1:0] dsack_q, dsack_d;

    logic window, active, drive_on;
    logic unused_inputs;

    assign unused_inputs = ^{DS20, A[11:5], A[1:0]};

    // The whole $DA0000-$DA3FFF window answers ACCESS; only A[13]=1 reaches the drive.
    assign window = (A[31:14] == {16'h00DA, 2'b00}) && !AS20;
    assign ACCESS = !window;
    assign active = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        iordy_d   = iordy_q;
        rw_d      = rw_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        dummy_d   = dummy_q;
        abort_d   = abort_q || (AS20 && active);
        armed_d   = AS20 ? 1'b1 : armed_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (window && armed_q) begin
                    armed_d = 1'b0;
                    abort_d = 1'b0;
                    rw_d    = RW;
                    sel_d   = A[12];
                    addr_d  = A[4:2];
                    dummy_d = !A[13];
                    phase_d = 4'd0;
                    iordy_d = 8'd0;
                    state_d = A[13] ? S_SETUP : S_ACK;
                end
            end
            S_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    phase_d = 4'd0;
                    state_d = S_STROBE;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_STROBE: begin
                // IORDY only matters once the minimum strobe width has elapsed.
                if (phase_q != STROBE_LAST) begin
                    phase_d = phase_q + 4'd1;
                end else if (IORDY || (iordy_q == IORDY_LAST)) begin
                    phase_d = 4'd0;
                    iordy_d = 8'd0;
                    state_d = S_HOLD;
                    if (!IORDY) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    iordy_d = iordy_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    phase_d = 4'd0;
                    state_d = (abort_q || AS20) ? S_IDLE : S_ACK;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_ACK: begin
                if (AS20) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs follow the state one clock later; the ACK exit reacts to AS20 directly.
    always_comb begin
        drive_on   = active || ((state_q == S_ACK) && rw_q && !dummy_q && !AS20);
        cs0_d      = !(active && !sel_q);
        cs1_d      = !(active && sel_q);
        ide_a_d    = active ? addr_q : 3'd0;
        ior_d      = !((state_q == S_STROBE) && rw_q);
        iow_d      = !((state_q == S_STROBE) && !rw_q);
        dben_d     = !drive_on;
        dir_d      = drive_on && rw_q;
        rd_latch_d = (state_q == S_STROBE) && (state_d == S_HOLD) && rw_q;
        dsack_d    = ((state_q == S_ACK) && !AS20) ? 2'b01 : 2'b11;
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            phase_q    <= 4'd0;
            iordy_q    <= 8'd0;
            rw_q       <= 1'b0;
            sel_q      <= 1'b0;
            addr_q     <= 3'd0;
            dummy_q    <= 1'b0;
            abort_q    <= 1'b0;
            armed_q    <= 1'b1;
            timeout_q  <= 1'b0;
            cs0_q      <= 1'b1;
            cs1_q      <= 1'b1;
            ide_a_q    <= 3'd0;
            ior_q      <= 1'b1;
            iow_q      <= 1'b1;
            dben_q     <= 1'b1;
            dir_q      <= 1'b0;
            rd_latch_q <= 1'b0;
            dsack_q    <= 2'b11;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            iordy_q    <= iordy_d;
            rw_q       <= rw_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            dummy_q    <= dummy_d;
            abort_q    <= abort_d;
            armed_q    <= armed_d;
            timeout_q  <= timeout_d;
            cs0_q      <= cs0_d;
            cs1_q      <= cs1_d;
            ide_a_q    <= ide_a_d;
            ior_q      <= ior_d;
            iow_q      <= iow_d;
            dben_q     <= dben_d;
            dir_q      <= dir_d;
            rd_latch_q <= rd_latch_d;
            dsack_q    <= dsack_d;
        end
    end

    assign IDE_CS0  = cs0_q;
    assign IDE_CS1  = cs1_q;
    assign IDE_A    = ide_a_q;
    assign IDE_IOR  = ior_q;
    assign IDE_IOW  = iow_q;
    assign IDE_DBEN = dben_q;
    assign IDE_DIR  = dir_q;
    assign RD_LATCH = rd_latch_q;
    assign DSACK    = dsack_q;
    assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// Scoreboard bench for ide_cycle_ctrl: expected cycle shapes are queued when an
// access is launched and compared against what the drive-side pins actually did.
module tb_ide_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        as20 = 1'b1;
    logic        ds20 = 1'b1;
    logic        rw = 1'b1;
    logic [31:0] addr = 32'd0;
    logic        iordy = 1'b1;
    logic        access, cs0, cs1, ior, iow, dben, dir, rd_latch, timeout;
    logic [2:0]  ide_a;
    logic [1:0]  dsack;

    always #5 clk = ~clk;

    ide_cycle_ctrl dut (
        .CLKCPU(clk), .RESET(reset), .AS20(as20), .DS20(ds20), .RW(rw), .A(addr),
        .IORDY(iordy), .ACCESS(access), .IDE_CS0(cs0), .IDE_CS1(cs1), .IDE_A(ide_a),
        .IDE_IOR(ior), .IDE_IOW(iow), .IDE_DBEN(dben), .IDE_DIR(dir),
        .RD_LATCH(rd_latch), .DSACK(dsack), .TIMEOUT(timeout)
    );

    typedef struct {
        int         cs_first;
        logic [1:0] cs;
        logic [2:0] a;
        logic       dir;
        int         strb_first;
        int         strb_len;
        int         ior_len;
        int         pulses;
        int         rdl_idx;
        int         rdl_cnt;
        int         ack_idx;
        logic       dben_ack;
        logic [1:0] cs_ack;
        logic [1:0] dsack_after;
        logic       dben_after;
        logic       both_cs;
    } cyc_t;

    cyc_t sb[$];
    cyc_t obs;
    cyc_t e;
    int   total = 0;
    int   bad = 0;

    function automatic cyc_t blank();
        cyc_t c;
        c.cs_first = -1; c.cs = 2'b11; c.a = 3'd0; c.dir = 1'b0;
        c.strb_first = -1; c.strb_len = 0; c.ior_len = 0; c.pulses = 0;
        c.rdl_idx = -1; c.rdl_cnt = 0; c.ack_idx = -1; c.dben_ack = 1'b1;
        c.cs_ack = 2'b11; c.dsack_after = 2'b11; c.dben_after = 1'b1; c.both_cs = 1'b0;
        return c;
    endfunction

    // Builds the expected shape of a drive cycle launched at edge N with default timing.
    function automatic cyc_t drive_cycle(input logic [1:0] cs_v, input logic [2:0] a_v,
                                         input logic is_read, input int strobe_len);
        cyc_t c;
        c = blank();
        c.cs_first   = 1;
        c.cs         = cs_v;
        c.a          = a_v;
        c.dir        = is_read;
        c.strb_first = 3;
        c.strb_len   = strobe_len;
        c.ior_len    = is_read ? strobe_len : 0;
        c.pulses     = 1;
        c.rdl_idx    = is_read ? 3 + strobe_len - 1 : -1;
        c.rdl_cnt    = is_read ? 1 : 0;
        c.ack_idx    = 3 + strobe_len + 1;
        c.dben_ack   = !is_read;
        return c;
    endfunction

    task automatic start_access(input logic [31:0] a_in, input logic rw_in);
        addr = a_in;
        rw   = rw_in;
        as20 = 1'b0;
        ds20 = 1'b0;
    endtask

    // Records the pins edge by edge; called at #1 after an edge with AS20 already low.
    task automatic measure(input int release_at, input int iordy_after, input int stop_k);
        int   rel_k;
        logic prev_strb;
        logic strb;
        bit   ack_rel;
        rel_k     = -1;
        prev_strb = 1'b1;
        ack_rel   = (release_at < 0);
        obs       = blank();
        @(posedge clk);
        #1;
        for (int k = 1; k <= stop_k; k++) begin
            @(posedge clk);
            #1;
            strb = ior & iow;
            if (cs0 === 1'b0 && cs1 === 1'b0) obs.both_cs = 1'b1;
            if (obs.cs_first < 0 && (cs0 === 1'b0 || cs1 === 1'b0)) begin
                obs.cs_first = k; obs.cs = {cs1, cs0}; obs.a = ide_a; obs.dir = dir;
            end
            if (ior === 1'b0) obs.ior_len++;
            if (strb === 1'b0) begin
                obs.strb_len++;
                if (obs.strb_first < 0) obs.strb_first = k;
                if (iordy_after >= 0 && obs.strb_len == iordy_after) iordy = 1'b1;
            end
            if (prev_strb === 1'b1 && strb === 1'b0) obs.pulses++;
            prev_strb = strb;
            if (rd_latch === 1'b1) begin obs.rdl_cnt++; obs.rdl_idx = k; end
            if (rel_k >= 0 && k == rel_k + 1) begin
                obs.dsack_after = dsack; obs.dben_after = dben;
                if (ack_rel) break;
            end
            if (dsack === 2'b01 && obs.ack_idx < 0) begin
                obs.ack_idx = k; obs.dben_ack = dben; obs.cs_ack = {cs1, cs0};
                if (ack_rel) begin as20 = 1'b1; ds20 = 1'b1; rel_k = k; end
            end
            if (k == release_at) begin as20 = 1'b1; ds20 = 1'b1; rel_k = k; end
        end
        as20  = 1'b1;
        ds20  = 1'b1;
        iordy = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        total++; if ({cs0, cs1, ior, iow, dben, dsack, rd_latch, ide_a, dir, timeout} !== 13'b1111111000000) begin bad++; $display("FAIL reset_outputs got=%b want=%b", {cs0, cs1, ior, iow, dben, dsack, rd_latch, ide_a, dir, timeout}, 13'b1111111000000); end
        reset = 1'b0;
        idle(2);
        total++; if (access !== 1'b1) begin bad++; $display("FAIL reset_access got=%b want=1", access); end
    endtask

    task automatic test_write();
        sb.push_back(drive_cycle(2'b10, 3'd2, 1'b0, 6));
        start_access(32'h00DA_2008, 1'b0);
        #1;
        total++; if (access !== 1'b0) begin bad++; $display("FAIL wr_access got=%b want=0", access); end
        measure(-1, -1, 40);
        e = sb.pop_front();
        total++; if (obs.cs_first !== e.cs_first || obs.cs !== e.cs || obs.a !== e.a || obs.dir !== e.dir) begin bad++; $display("FAIL wr_select got=%0d/%b/%0d/%b want=%0d/%b/%0d/%b", obs.cs_first, obs.cs, obs.a, obs.dir, e.cs_first, e.cs, e.a, e.dir); end
        total++; if (obs.strb_first !== e.strb_first || obs.strb_len !== e.strb_len || obs.ior_len !== e.ior_len) begin bad++; $display("FAIL wr_strobe got=%0d/%0d/%0d want=%0d/%0d/%0d", obs.strb_first, obs.strb_len, obs.ior_len, e.strb_first, e.strb_len, e.ior_len); end
        total++; if (obs.ack_idx !== e.ack_idx || obs.cs_ack !== 2'b11 || obs.dben_ack !== e.dben_ack) begin bad++; $display("FAIL wr_ack got=%0d/%b/%b want=%0d/11/%b", obs.ack_idx, obs.cs_ack, obs.dben_ack, e.ack_idx, e.dben_ack); end
        total++; if (obs.rdl_cnt !== 0 || obs.both_cs !== 1'b0 || obs.dsack_after !== 2'b11) begin bad++; $display("FAIL wr_misc got=%0d/%b/%b want=0/0/11", obs.rdl_cnt, obs.both_cs, obs.dsack_after); end
        idle(2);
    endtask

    task automatic test_read();
        sb.push_back(drive_cycle(2'b01, 3'd6, 1'b1, 6));
        start_access(32'h00DA_3018, 1'b1);
        measure(-1, -1, 40);
        e = sb.pop_front();
        total++; if (obs.cs_first !== e.cs_first || obs.cs !== e.cs || obs.a !== e.a || obs.dir !== e.dir) begin bad++; $display("FAIL rd_select got=%0d/%b/%0d/%b want=%0d/%b/%0d/%b", obs.cs_first, obs.cs, obs.a, obs.dir, e.cs_first, e.cs, e.a, e.dir); end
        total++; if (obs.strb_len !== e.strb_len || obs.ior_len !== e.ior_len || obs.rdl_idx !== e.rdl_idx || obs.rdl_cnt !== e.rdl_cnt) begin bad++; $display("FAIL rd_strobe got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", obs.strb_len, obs.ior_len, obs.rdl_idx, obs.rdl_cnt, e.strb_len, e.ior_len, e.rdl_idx, e.rdl_cnt); end
        total++; if (obs.ack_idx !== e.ack_idx || obs.dben_ack !== 1'b0 || obs.dben_after !== 1'b1 || obs.dsack_after !== 2'b11) begin bad++; $display("FAIL rd_ack got=%0d/%b/%b/%b want=%0d/0/1/11", obs.ack_idx, obs.dben_ack, obs.dben_after, obs.dsack_after, e.ack_idx); end
        idle(2);
    endtask

    task automatic test_iordy();
        sb.push_back(drive_cycle(2'b10, 3'd1, 1'b1, 26));
        iordy = 1'b0;
        start_access(32'h00DA_2004, 1'b1);
        measure(-1, 25, 100);
        e = sb.pop_front();
        total++; if (obs.strb_first !== e.strb_first || obs.ior_len !== e.ior_len || obs.rdl_idx !== e.rdl_idx || obs.ack_idx !== e.ack_idx) begin bad++; $display("FAIL iordy_ext got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", obs.strb_first, obs.ior_len, obs.rdl_idx, obs.ack_idx, e.strb_first, e.ior_len, e.rdl_idx, e.ack_idx); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL iordy_ext_timeout got=%b want=0", timeout); end
        idle(2);
        sb.push_back(drive_cycle(2'b10, 3'd1, 1'b1, 6 + 255));
        iordy = 1'b0;
        start_access(32'h00DA_2004, 1'b1);
        measure(-1, -1, 300);
        e = sb.pop_front();
        total++; if (obs.ior_len !== e.ior_len || obs.rdl_idx !== e.rdl_idx || obs.ack_idx !== e.ack_idx) begin bad++; $display("FAIL iordy_stuck got=%0d/%0d/%0d want=%0d/%0d/%0d", obs.ior_len, obs.rdl_idx, obs.ack_idx, e.ior_len, e.rdl_idx, e.ack_idx); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL iordy_stuck_timeout got=%b want=1", timeout); end
        idle(2);
        sb.push_back(drive_cycle(2'b10, 3'd2, 1'b0, 6));
        start_access(32'h00DA_2008, 1'b0);
        measure(-1, -1, 40);
        e = sb.pop_front();
        total++; if (obs.ack_idx !== e.ack_idx || timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0d/%b want=%0d/1", obs.ack_idx, timeout, e.ack_idx); end
        idle(2);
    endtask

    task automatic test_abort_reset();
        bit saw_ack;
        e = drive_cycle(2'b01, 3'd3, 1'b0, 6);
        e.ack_idx = -1;
        sb.push_back(e);
        start_access(32'h00DA_300C, 1'b0);
        measure(1, -1, 16);
        e = sb.pop_front();
        total++; if (obs.cs_first !== e.cs_first || obs.cs !== e.cs || obs.a !== e.a) begin bad++; $display("FAIL abort_select got=%0d/%b/%0d want=%0d/%b/%0d", obs.cs_first, obs.cs, obs.a, e.cs_first, e.cs, e.a); end
        total++; if (obs.strb_first !== e.strb_first || obs.strb_len !== e.strb_len || obs.pulses !== e.pulses) begin bad++; $display("FAIL abort_strobe got=%0d/%0d/%0d want=%0d/%0d/%0d", obs.strb_first, obs.strb_len, obs.pulses, e.strb_first, e.strb_len, e.pulses); end
        total++; if (obs.ack_idx !== -1 || {cs1, cs0, dsack} !== 4'b1111) begin bad++; $display("FAIL abort_noack got=%0d/%b want=-1/1111", obs.ack_idx, {cs1, cs0, dsack}); end
        idle(2);
        start_access(32'h00DA_2000, 1'b1);
        idle(6);
        total++; if (ior !== 1'b0) begin bad++; $display("FAIL midstrobe_ior got=%b want=0", ior); end
        reset = 1'b1;
        as20  = 1'b1;
        ds20  = 1'b1;
        idle(1);
        total++; if ({cs0, cs1, ior, iow, dben, dsack, rd_latch, ide_a, dir, timeout} !== 13'b1111111000000) begin bad++; $display("FAIL midstrobe_reset got=%b want=%b", {cs0, cs1, ior, iow, dben, dsack, rd_latch, ide_a, dir, timeout}, 13'b1111111000000); end
        reset   = 1'b0;
        saw_ack = 1'b0;
        for (int k = 0; k < 12; k++) begin
            idle(1);
            if (dsack !== 2'b11 || ior !== 1'b1) saw_ack = 1'b1;
        end
        total++; if (saw_ack !== 1'b0) begin bad++; $display("FAIL postreset_quiet got=%b want=0", saw_ack); end
    endtask

    task automatic test_decode();
        start_access(32'h00DA_8000, 1'b1);
        #1;
        total++; if (access !== 1'b1) begin bad++; $display("FAIL gayle_access got=%b want=1", access); end
        measure(-1, -1, 12);
        total++; if (obs.cs_first !== -1 || obs.strb_len !== 0 || obs.ack_idx !== -1) begin bad++; $display("FAIL gayle_quiet got=%0d/%0d/%0d want=-1/0/-1", obs.cs_first, obs.strb_len, obs.ack_idx); end
        idle(2);
        e = blank();
        e.ack_idx = 1;
        sb.push_back(e);
        start_access(32'h00DA_1000, 1'b1);
        #1;
        total++; if (access !== 1'b0) begin bad++; $display("FAIL dummy_access got=%b want=0", access); end
        measure(-1, -1, 10);
        e = sb.pop_front();
        total++; if (obs.cs_first !== e.cs_first || obs.strb_len !== e.strb_len || obs.ack_idx !== e.ack_idx || obs.dsack_after !== 2'b11) begin bad++; $display("FAIL dummy_ack got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/11", obs.cs_first, obs.strb_len, obs.ack_idx, obs.dsack_after, e.cs_first, e.strb_len, e.ack_idx); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        sb.push_back(drive_cycle(2'b10, 3'd4, 1'b0, 6));
        start_access(32'h00DA_2010, 1'b0);
        measure(40, -1, 45);
        e = sb.pop_front();
        total++; if (obs.pulses !== 1 || obs.strb_len !== e.strb_len || obs.a !== e.a) begin bad++; $display("FAIL b2b_pulses got=%0d/%0d/%0d want=1/%0d/%0d", obs.pulses, obs.strb_len, obs.a, e.strb_len, e.a); end
        total++; if (obs.ack_idx !== e.ack_idx || obs.dsack_after !== 2'b11) begin bad++; $display("FAIL b2b_ack got=%0d/%b want=%0d/11", obs.ack_idx, obs.dsack_after, e.ack_idx); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_iordy();
        test_abort_reset();
        test_decode();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
